// File: rtl/ex_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_if
//  Purpose  : Bundles the ID->EX operand/control bus and the EX->MEM /
//             EX->IF result bus of the MIPS execute stage.
//  Ports    : master - upstream/test side (drives id operands, sees results)
//             slave  - ex_stage side (receives id operands, drives results)
//  Signals  : valid_in/ready_out/hazard handshake, opcode_in, pc4_in, rs_val,
//             rt_val, imm_in, dest_addr_in, id controls; valid_out, addr_in,
//             addr_reg_in, write_data, mem controls, branch_taken/target
//  Revision : 1.0 - initial release
// ============================================================================
interface ex_if #(
  parameter int D_SIZE        = 32,
  parameter int ADDR_LINE_REG = 5
);
  // id -> ex
  logic                     valid_in;
  logic [5:0]               opcode_in;
  logic [D_SIZE-1:0]        pc4_in;
  logic [D_SIZE-1:0]        rs_val;
  logic [D_SIZE-1:0]        rt_val;
  logic [D_SIZE-1:0]        imm_in;
  logic [ADDR_LINE_REG-1:0] dest_addr_in;
  logic                     branch_in;
  logic                     mem_read_in;
  logic                     mem_to_reg_in;
  logic                     mem_write_in;
  // ex -> id / inst_f
  logic                     ready_out;
  logic                     hazard;
  logic                     branch_taken;
  logic [D_SIZE-1:0]        branch_target;
  // ex -> mem
  logic                     valid_out;
  logic [D_SIZE-1:0]        addr_in;
  logic [ADDR_LINE_REG-1:0] addr_reg_in;
  logic [D_SIZE-1:0]        write_data;
  logic                     mem_read;
  logic                     mem_write;
  logic                     mem_to_reg;

  modport master (
    output valid_in, opcode_in, pc4_in, rs_val, rt_val, imm_in, dest_addr_in,
           branch_in, mem_read_in, mem_to_reg_in, mem_write_in,
    input  ready_out, hazard, branch_taken, branch_target, valid_out, addr_in,
           addr_reg_in, write_data, mem_read, mem_write, mem_to_reg
  );

  modport slave (
    input  valid_in, opcode_in, pc4_in, rs_val, rt_val, imm_in, dest_addr_in,
           branch_in, mem_read_in, mem_to_reg_in, mem_write_in,
    output ready_out, hazard, branch_taken, branch_target, valid_out, addr_in,
           addr_reg_in, write_data, mem_read, mem_write, mem_to_reg
  );
endinterface
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage
//  Purpose  : Execute stage of a 5-stage MIPS pipeline. Computes the ALU
//             result / memory address and the branch decision, and registers
//             everything into the EX/MEM pipeline register. MUL is a
//             shift-and-add multiplier (one multiplier bit per cycle) that
//             stalls upstream while it runs.
//  Ports    : clk   - rising-edge clock
//             reset - asynchronous active-low reset
//             bus   - ex_if.slave (id operands in, EX/MEM + redirect out)
//  Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
  parameter int D_SIZE        = 32,
  parameter int ADDR_LINE_REG = 5
) (
  input  wire logic clk,
  input  wire logic reset,
  ex_if.slave       bus
);

  localparam int SH_W  = $clog2(D_SIZE);
  localparam int CNT_W = $clog2(D_SIZE);

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_XOR  = 6'h04;
  localparam logic [5:0] OP_SLT  = 6'h05;
  localparam logic [5:0] OP_SLL  = 6'h06;
  localparam logic [5:0] OP_SRL  = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h09;
  localparam logic [5:0] OP_SW   = 6'h0A;
  localparam logic [5:0] OP_BEQ  = 6'h0B;
  localparam logic [5:0] OP_BNE  = 6'h0C;
  localparam logic [5:0] OP_MUL  = 6'h0D;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [D_SIZE-1:0]        mcand_q, mcand_d;
  logic [D_SIZE-1:0]        mplier_q, mplier_d;
  logic [D_SIZE-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  // Destination and controls of the MUL in flight, replayed in DONE
  logic [ADDR_LINE_REG-1:0] mdest_q, mdest_d;
  logic                     mrd_q, mrd_d;
  logic                     mwr_q, mwr_d;
  logic                     mm2r_q, mm2r_d;

  // EX/MEM pipeline register
  logic                     valid_q, valid_d;
  logic [D_SIZE-1:0]        addr_q, addr_d;
  logic [ADDR_LINE_REG-1:0] areg_q, areg_d;
  logic [D_SIZE-1:0]        wdata_q, wdata_d;
  logic                     rd_q, rd_d;
  logic                     wr_q, wr_d;
  logic                     m2r_q, m2r_d;
  logic                     taken_q, taken_d;
  logic [D_SIZE-1:0]        target_q, target_d;

  logic              busy;
  logic              accept;
  logic [D_SIZE-1:0] alu_res;
  logic              op_known;
  logic              br_cond;
  logic [D_SIZE-1:0] br_target;

  assign busy          = (state_q != S_IDLE);
  assign accept        = bus.valid_in && !busy;
  assign bus.ready_out = !busy;
  assign bus.hazard    = busy;
  assign br_target     = bus.pc4_in + (bus.imm_in << 2);

  // Single-cycle ALU and branch comparator
  always_comb begin
    alu_res  = '0;
    op_known = 1'b1;
    br_cond  = 1'b0;
    case (bus.opcode_in)
      OP_ADD:  alu_res = bus.rs_val + bus.rt_val;
      OP_SUB:  alu_res = bus.rs_val - bus.rt_val;
      OP_AND:  alu_res = bus.rs_val & bus.rt_val;
      OP_OR:   alu_res = bus.rs_val | bus.rt_val;
      OP_XOR:  alu_res = bus.rs_val ^ bus.rt_val;
      OP_SLT:  alu_res = {{(D_SIZE-1){1'b0}},
                          ($signed(bus.rs_val) < $signed(bus.rt_val))};
      OP_SLL:  alu_res = bus.rs_val << bus.rt_val[SH_W-1:0];
      OP_SRL:  alu_res = bus.rs_val >> bus.rt_val[SH_W-1:0];
      OP_ADDI,
      OP_LW,
      OP_SW:   alu_res = bus.rs_val + bus.imm_in;
      // Branches report the comparison difference; the decision is br_cond
      OP_BEQ: begin
        alu_res = bus.rs_val - bus.rt_val;
        br_cond = (bus.rs_val == bus.rt_val);
      end
      OP_BNE: begin
        alu_res = bus.rs_val - bus.rt_val;
        br_cond = (bus.rs_val != bus.rt_val);
      end
      OP_MUL:  alu_res = '0;
      default: op_known = 1'b0;
    endcase
  end

  // Next-state: FSM, multiplier datapath and EX/MEM register contents.
  // Every cycle defaults to a bubble; data fields hold their last value.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mdest_d  = mdest_q;
    mrd_d    = mrd_q;
    mwr_d    = mwr_q;
    mm2r_d   = mm2r_q;
    valid_d  = 1'b0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    m2r_d    = 1'b0;
    taken_d  = 1'b0;
    addr_d   = addr_q;
    areg_d   = areg_q;
    wdata_d  = wdata_q;
    target_d = target_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.opcode_in == OP_MUL) begin
            mcand_d  = bus.rs_val;
            mplier_d = bus.rt_val;
            acc_d    = '0;
            cnt_d    = '0;
            mdest_d  = bus.dest_addr_in;
            mrd_d    = bus.mem_read_in;
            mwr_d    = bus.mem_write_in;
            mm2r_d   = bus.mem_to_reg_in;
            state_d  = S_MUL;
          end else begin
            valid_d = 1'b1;
            addr_d  = alu_res;
            areg_d  = bus.dest_addr_in;
            wdata_d = bus.rt_val;
            if (op_known) begin
              rd_d    = bus.mem_read_in;
              wr_d    = bus.mem_write_in;
              m2r_d   = bus.mem_to_reg_in;
              taken_d = bus.branch_in && br_cond;
            end
            // Target only moves on a real redirect so it holds otherwise
            if (taken_d) begin
              target_d = br_target;
            end
          end
        end
      end
      S_MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(D_SIZE - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        valid_d = 1'b1;
        addr_d  = acc_q;
        areg_d  = mdest_q;
        rd_d    = mrd_q;
        wr_d    = mwr_q;
        m2r_d   = mm2r_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mdest_q  <= '0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      mm2r_q   <= 1'b0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      areg_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      m2r_q    <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mdest_q  <= mdest_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
      mm2r_q   <= mm2r_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      areg_q   <= areg_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      m2r_q    <= m2r_d;
      taken_q  <= taken_d;
      target_q <= target_d;
    end
  end

  assign bus.valid_out     = valid_q;
  assign bus.addr_in       = addr_q;
  assign bus.addr_reg_in   = areg_q;
  assign bus.write_data    = wdata_q;
  assign bus.mem_read      = rd_q;
  assign bus.mem_write     = wr_q;
  assign bus.mem_to_reg    = m2r_q;
  assign bus.branch_taken  = taken_q;
  assign bus.branch_target = target_q;

endmodule
`default_nettype wire
